// File: rtl/regbank_pkg.sv
// Shared encodings for the register-bank sequencer: opcodes, FSM states, default widths.
package regbank_pkg;

    localparam int REGBANK_DATA_W = 32;
    localparam int REGBANK_ADDR_W = 2;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_COPY  = 2'd2;
    localparam logic [1:0] OP_SWAP  = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd1;
    localparam logic [2:0] ST_SW1  = 3'd2;
    localparam logic [2:0] ST_SW2  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

endpackage

// File: rtl/regbank_ctrl.sv
// Sequencer driving a 4x32 register bank for WRITE/READ/COPY/SWAP commands (REGBANK_CTRL_R0_ZERO_EN hardwires r0 to zero).
// Latency: response valid two cycles after accept (four for SWAP).
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until rsp_ready.
module regbank_ctrl
    import regbank_pkg::*;
#(
    parameter int DATA_W = REGBANK_DATA_W,
    parameter int ADDR_W = REGBANK_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_a,
    input  logic [ADDR_W-1:0] cmd_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic [ADDR_W-1:0] sr1,
    output logic [ADDR_W-1:0] sr2,
    output logic [ADDR_W-1:0] dr,
    output logic              write,
    output logic [DATA_W-1:0] wrData,
    input  logic [DATA_W-1:0] rdData1,
    input  logic [DATA_W-1:0] rdData2
);

    logic [2:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rsp1_q, rsp1_d, rsp2_q, rsp2_d;
    logic [DATA_W-1:0] rd1_eff, rd2_eff;
    logic              wr_req;

    // Read selects always equal a_q/b_q whenever read data is consumed, so mask on those.
`ifdef REGBANK_CTRL_R0_ZERO_EN
    assign rd1_eff = (a_q == '0) ? '0 : rdData1;
    assign rd2_eff = (b_q == '0) ? '0 : rdData2;
    assign write   = wr_req && rst_n && (dr != '0);
`else
    assign rd1_eff = rdData1;
    assign rd2_eff = rdData2;
    assign write   = wr_req && rst_n;
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data1 = rsp1_q;
    assign rsp_data2 = rsp2_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        rsp1_d  = rsp1_q;
        rsp2_d  = rsp2_q;
        sr1     = '0;
        sr2     = '0;
        dr      = '0;
        wrData  = '0;
        wr_req  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    data_d  = cmd_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_WRITE: begin
                        dr     = a_q;
                        wrData = data_q;
                        wr_req = 1'b1;
                        rsp1_d = data_q;
                        rsp2_d = '0;
                    end
                    OP_READ: begin
                        sr1    = a_q;
                        sr2    = b_q;
                        rsp1_d = rd1_eff;
                        rsp2_d = rd2_eff;
                    end
                    OP_COPY: begin
                        sr1    = a_q;
                        dr     = b_q;
                        wrData = rd1_eff;
                        wr_req = 1'b1;
                        rsp1_d = rd1_eff;
                        rsp2_d = rd1_eff;
                    end
                    default: begin
                        sr1    = a_q;
                        sr2    = b_q;
                        rsp1_d = rd1_eff;
                        rsp2_d = rd2_eff;
                    end
                endcase
                state_d = (op_q == OP_SWAP) ? ST_SW1 : ST_RESP;
            end
            // Swap write-back uses the captured response words as temporaries.
            ST_SW1: begin
                dr      = a_q;
                wrData  = rsp2_q;
                wr_req  = 1'b1;
                state_d = ST_SW2;
            end
            ST_SW2: begin
                dr      = b_q;
                wrData  = rsp1_q;
                wr_req  = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_WRITE;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            rsp1_q  <= '0;
            rsp2_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            rsp1_q  <= rsp1_d;
            rsp2_q  <= rsp2_d;
        end
    end

endmodule

// File: tb/tb_regbank_ctrl.sv
// Bench for regbank_ctrl: register bank model, directed literal cases, randomized commands vs a behavioural model.
module tb_regbank_ctrl;

    localparam logic [1:0] W_OP = 2'd0, R_OP = 2'd1, C_OP = 2'd2, S_OP = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op, cmd_a, cmd_b;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data1, rsp_data2;
    logic [1:0]  sr1, sr2, dr;
    logic        write;
    logic [31:0] wrData, rdData1, rdData2;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    bit armed  = 0;

    always #5 clk = ~clk;

    regbank_ctrl #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .sr1(sr1), .sr2(sr2), .dr(dr), .write(write), .wrData(wrData),
        .rdData1(rdData1), .rdData2(rdData2)
    );

    // Register bank: async reads, write on the clock edge.
    logic [31:0] bank [4] = '{default: 32'h0};
    assign rdData1 = bank[sr1];
    assign rdData2 = bank[sr2];
    always @(posedge clk) begin
        if (write === 1'b1) begin
            bank[dr] <= wrData;
            wr_cnt   <= wr_cnt + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    endtask

    // Reference model: bank contents plus the command in flight.
    logic [31:0] ref_bank [4] = '{default: 32'h0};
    bit          pend = 0, post_rst = 1;
    int          cyc, lat_m;
    logic [1:0]  m_op, m_a, m_b;
    logic [31:0] m_d, e1, e2;

    function automatic logic [31:0] rd_ref(input logic [1:0] i);
`ifdef REGBANK_CTRL_R0_ZERO_EN
        if (i == 2'd0) return 32'h0;
`endif
        return ref_bank[i];
    endfunction

    always @(negedge clk) begin
        bit          exp_w;
        logic [1:0]  w_idx;
        logic [31:0] w_val;
        if (armed) begin
            if (!rst_n) begin
                check("write_gated_in_reset", {31'b0, write}, 32'd0);
                pend     = 0;
                post_rst = 1;
            end else if (pend) begin
                cyc++;
                check("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
                check("rsp_valid_timing", {31'b0, rsp_valid}, (cyc >= lat_m) ? 32'd1 : 32'd0);
                if (cyc == 1) begin
                    case (m_op)
                        W_OP:    begin e1 = m_d;          e2 = 32'h0;        end
                        C_OP:    begin e1 = rd_ref(m_a);  e2 = rd_ref(m_a);  end
                        default: begin e1 = rd_ref(m_a);  e2 = rd_ref(m_b);  end
                    endcase
                    if (m_op != W_OP) check("sr1_exec", {30'b0, sr1}, {30'b0, m_a});
                    if (m_op == R_OP || m_op == S_OP) check("sr2_exec", {30'b0, sr2}, {30'b0, m_b});
                end
                exp_w = 0; w_idx = 2'd0; w_val = 32'h0;
                if (m_op == W_OP && cyc == 1) begin exp_w = 1; w_idx = m_a; w_val = m_d; end
                if (m_op == C_OP && cyc == 1) begin exp_w = 1; w_idx = m_b; w_val = e1;  end
                if (m_op == S_OP && cyc == 2) begin exp_w = 1; w_idx = m_a; w_val = e2;  end
                if (m_op == S_OP && cyc == 3) begin exp_w = 1; w_idx = m_b; w_val = e1;  end
`ifdef REGBANK_CTRL_R0_ZERO_EN
                if (exp_w && w_idx == 2'd0) exp_w = 0;
`endif
                check("write_en", {31'b0, write}, {31'b0, exp_w});
                if (exp_w) begin
                    check("write_dr", {30'b0, dr}, {30'b0, w_idx});
                    check("write_data", wrData, w_val);
                    ref_bank[w_idx] = w_val;
                end
                if (cyc >= lat_m) begin
                    check("rsp_data1", rsp_data1, e1);
                    check("rsp_data2", rsp_data2, e2);
                    if (rsp_ready) pend = 0;
                end
            end else begin
                check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
                check("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);
                check("write_idle", {31'b0, write}, 32'd0);
                check("selects_idle", {24'b0, sr1, sr2, dr, 2'b0}, 32'd0);
                check("wrdata_idle", wrData, 32'd0);
                if (post_rst) begin
                    check("rsp_data1_reset", rsp_data1, 32'd0);
                    check("rsp_data2_reset", rsp_data2, 32'd0);
                    post_rst = 0;
                end
                if (cmd_valid) begin
                    pend  = 1;
                    cyc   = 0;
                    m_op  = cmd_op;
                    m_a   = cmd_a;
                    m_b   = cmd_b;
                    m_d   = cmd_data;
                    lat_m = (cmd_op == S_OP) ? 4 : 2;
                end
            end
        end
    end

    // Drivers operate in the phase #1 after a rising edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b, input logic [31:0] d);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_a     = 2'($urandom_range(0, 3));
        cmd_b     = 2'($urandom_range(0, 3));
        cmd_data  = $urandom;
    endtask

    task automatic collect(input int stall, output logic [31:0] r1, output logic [31:0] r2, output int lat);
        lat = 1; rsp_ready = 0; r1 = 32'h0; r2 = 32'h0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("rsp_arrives", {31'b0, rsp_valid}, 32'd1);
        if (rsp_valid) begin
            repeat (stall) begin @(posedge clk); #1; end
            r1 = rsp_data1; r2 = rsp_data2; rsp_ready = 1;
            @(posedge clk); #1;
            rsp_ready = 0;
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b, input logic [31:0] d,
                          input int stall, output logic [31:0] r1, output logic [31:0] r2, output int lat);
        issue(op, a, b, d);
        collect(stall, r1, r2, lat);
    endtask

    initial begin
        logic [31:0] r1, r2, x1;
        int lat, wc0;
        rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_data = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_write", {31'b0, write}, 32'd0);
        check("reset_rsp_data", rsp_data1 | rsp_data2, 32'd0);
        armed = 1;

        do_cmd(W_OP, 2, 0, 32'hDEADBEEF, 0, r1, r2, lat);
        check("write_rsp1", r1, 32'hDEADBEEF);
        check("write_rsp2", r2, 32'h0);
        check("write_latency", lat, 2);
        do_cmd(R_OP, 2, 0, 32'h0, 0, r1, r2, lat);
        check("read_r2", r1, 32'hDEADBEEF);
        check("read_r0", r2, 32'h0);
        check("read_latency", lat, 2);

        do_cmd(W_OP, 1, 0, 32'h11, 0, r1, r2, lat);
        do_cmd(W_OP, 3, 0, 32'h33, 0, r1, r2, lat);
        issue(S_OP, 1, 3, 32'h0);
        wc0 = wr_cnt;
        collect(0, r1, r2, lat);
        check("swap_rsp1", r1, 32'h11);
        check("swap_rsp2", r2, 32'h33);
        check("swap_latency", lat, 4);
        check("swap_write_count", wr_cnt - wc0, 2);
        do_cmd(R_OP, 1, 3, 32'h0, 0, r1, r2, lat);
        check("after_swap_r1", r1, 32'h33);
        check("after_swap_r3", r2, 32'h11);

`ifdef REGBANK_CTRL_R0_ZERO_EN
        x1 = 32'h0;
`else
        x1 = 32'hA5A5A5A5;
`endif
        do_cmd(W_OP, 0, 0, 32'hA5A5A5A5, 0, r1, r2, lat);
        check("write_r0_rsp", r1, 32'hA5A5A5A5);
        do_cmd(C_OP, 0, 3, 32'h0, 0, r1, r2, lat);
        do_cmd(R_OP, 3, 3, 32'h0, 0, r1, r2, lat);
        check("copy_r0_w1", r1, x1);
        check("copy_r0_w2", r2, x1);
        do_cmd(W_OP, 3, 0, 32'h33, 0, r1, r2, lat);

        // Stall in RESP while a WRITE is already offered.
        cmd_valid = 1; cmd_op = R_OP; cmd_a = 2; cmd_b = 1; cmd_data = 32'h0;
        @(posedge clk); #1;
        cmd_op = W_OP; cmd_a = 1; cmd_b = 0; cmd_data = 32'h77; rsp_ready = 0;
        repeat (11) begin @(posedge clk); #1; end
        check("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("stall_rsp1", rsp_data1, 32'hDEADBEEF);
        check("stall_rsp2", rsp_data2, 32'h33);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check("post_hs_idle", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 0;
        check("offered_accepted", {31'b0, cmd_ready}, 32'd0);
        collect(0, r1, r2, lat);
        check("offered_write_rsp", r1, 32'h77);
        do_cmd(R_OP, 1, 2, 32'h0, 0, r1, r2, lat);
        check("offered_write_vis", r1, 32'h77);

        // Reset during SW1 aborts the swap before any write.
        do_cmd(W_OP, 1, 0, 32'h1111, 0, r1, r2, lat);
        do_cmd(W_OP, 2, 0, 32'h2222, 0, r1, r2, lat);
        issue(S_OP, 1, 2, 32'h0);
        @(posedge clk); #1;
        rst_n = 0;
        wc0 = wr_cnt;
        @(posedge clk); #1;
        rst_n = 1;
        check("rst_no_write", wr_cnt - wc0, 0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data1", rsp_data1, 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        check("rst_no_stale_rsp", {31'b0, rsp_valid}, 32'd0);
        do_cmd(R_OP, 1, 2, 32'h0, 0, r1, r2, lat);
        check("rst_bank_r1", r1, 32'h1111);
        check("rst_bank_r2", r2, 32'h2222);

        for (int i = 0; i < 2000; i++) begin
            do_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom,
                   ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, r1, r2, lat);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) check("final_bank", bank[i], ref_bank[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
